// File: rtl/mips32_pkg.sv
// rtl/mips32_pkg.sv - shared pipe_MIPS32 opcodes and boot loader types
// Purpose: opcode constants shared with pipe_MIPS32, loader FSM state
//   encoding and loader error codes.
// Ports: none (package).
package mips32_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LOAD,
    LD_RUN,
    LD_DUMP,
    LD_DONE,
    LD_ERR
  } ld_state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_NOHLT   = 2'd1;
  localparam logic [1:0] ERR_RANGE   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/mips32_dump_seq.sv
// rtl/mips32_dump_seq.sv - readback issue counter with 1-cycle rdata alignment
// Purpose: on go, issues count reads starting at base (wrapping mod 2^ADDR_W,
//   folded mod MEM_DEPTH), one per cycle, and presents each word one cycle
//   after its read strobe together with the address it came from.
// Ports:
//   clk1, rst_n      clock, synchronous active-low reset
//   go               one-cycle pulse: latch base/count and start reading
//   base, count      first address and number of words (count > 0 when go)
//   mem_rdata        Mem read data, valid one cycle after mem_re
//   mem_re, rd_addr  read strobe and address (rd_addr is 0 when idle)
//   dump_valid/addr/data  readback word stream
//   dump_last        high with the final dump_valid
module mips32_dump_seq
  import mips32_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 1024
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              go,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] count,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_re,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last
);

  function automatic logic [ADDR_W-1:0] fold(input logic [ADDR_W-1:0] a);
    return ADDR_W'(32'(a) % 32'(MEM_DEPTH));
  endfunction

  logic              re_q, re_d;
  logic [ADDR_W-1:0] raw_q, raw_d;       // unfolded running address
  logic [ADDR_W-1:0] rem_q, rem_d;       // reads still to issue after the current one
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              val_q, val_d;
  logic [ADDR_W-1:0] vaddr_q, vaddr_d;
  logic              vlast_q, vlast_d;

  always_comb begin
    re_d      = 1'b0;
    raw_d     = raw_q;
    rem_d     = rem_q;
    rd_addr_d = '0;
    if (go) begin
      re_d      = (count != '0);
      raw_d     = base;
      rem_d     = count - 1'b1;
      rd_addr_d = (count != '0) ? fold(base) : '0;
    end else if (re_q && (rem_q != '0)) begin
      re_d      = 1'b1;
      raw_d     = raw_q + 1'b1;
      rem_d     = rem_q - 1'b1;
      rd_addr_d = fold(raw_q + 1'b1);
    end
    // The word for a read issued this cycle arrives next cycle; carry its
    // address and last-flag along so they line up with mem_rdata.
    val_d   = re_q;
    vaddr_d = re_q ? rd_addr_q : '0;
    vlast_d = re_q && (rem_q == '0);
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      re_q      <= 1'b0;
      raw_q     <= '0;
      rem_q     <= '0;
      rd_addr_q <= '0;
      val_q     <= 1'b0;
      vaddr_q   <= '0;
      vlast_q   <= 1'b0;
    end else begin
      re_q      <= re_d;
      raw_q     <= raw_d;
      rem_q     <= rem_d;
      rd_addr_q <= rd_addr_d;
      val_q     <= val_d;
      vaddr_q   <= vaddr_d;
      vlast_q   <= vlast_d;
    end
  end

  assign mem_re     = re_q;
  assign rd_addr    = rd_addr_q;
  assign dump_valid = val_q;
  assign dump_addr  = vaddr_q;
  assign dump_data  = val_q ? mem_rdata : '0;
  assign dump_last  = val_q & vlast_q;

endmodule

// File: rtl/mips32_boot_loader.sv
// rtl/mips32_boot_loader.sv - program loader, run supervisor and result dumper for pipe_MIPS32
// Purpose: writes an address+data beat stream into the core's Mem, releases
//   the core until it halts (with a watchdog), then streams a result window
//   of Mem back out.
// Ports:
//   clk1, rst_n                clock, synchronous active-low reset
//   start, dump_base, dump_count   session start and readback window
//   ld_valid/ready/addr/data/last  program image beat stream
//   mem_we/re/addr/wdata/rdata     core Mem port (rdata one cycle after re)
//   cpu_run, cpu_halted        core release and core HALTED flag
//   dump_valid/addr/data       readback stream, no backpressure
//   done, err, err_code        session status, held until next start
module mips32_boot_loader
  import mips32_pkg::*;
#(
  parameter int         ADDR_W         = 10,
  parameter int         DATA_W         = 32,
  parameter int         MEM_DEPTH      = 1024,
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter logic [5:0] HLT_OPCODE     = OP_HLT
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] dump_base,
  input  logic [ADDR_W-1:0] dump_count,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_run,
  input  logic              cpu_halted,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  ld_state_e         state_q, state_d;
  logic              hlt_seen_q, hlt_seen_d;
  logic              fin_q, fin_d;       // last beat taken, its write still in flight
  logic [31:0]       wd_q, wd_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              cpu_run_q, cpu_run_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              ld_fire;
  logic              in_range;
  logic              beat_hlt;
  logic              dump_go;
  logic              seq_re;
  logic [ADDR_W-1:0] seq_addr;
  logic              seq_last;

  assign ld_ready = (state_q == LD_LOAD) && !fin_q;
  assign ld_fire  = ld_valid && ld_ready;
  assign in_range = 32'(ld_addr) < 32'(MEM_DEPTH);
  assign beat_hlt = (ld_data[DATA_W-1 -: 6] == HLT_OPCODE);

  always_comb begin
    state_d    = state_q;
    hlt_seen_d = hlt_seen_q;
    fin_d      = fin_q;
    wd_d       = wd_q;
    base_d     = base_q;
    count_d    = count_q;
    done_d     = done_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    mem_we_d   = 1'b0;
    wa_d       = '0;
    wdata_d    = '0;
    dump_go    = 1'b0;
    unique case (state_q)
      LD_IDLE, LD_DONE, LD_ERR: begin
        if (start) begin
          state_d    = LD_LOAD;
          done_d     = 1'b0;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
          hlt_seen_d = 1'b0;
          fin_d      = 1'b0;
          base_d     = dump_base;
          count_d    = dump_count;
        end
      end
      LD_LOAD: begin
        if (fin_q) begin
          // Final write commits on this edge; release the core behind it.
          state_d = LD_RUN;
          fin_d   = 1'b0;
          wd_d    = '0;
        end else if (ld_fire) begin
          if (!in_range) begin
            state_d    = LD_ERR;
            err_d      = 1'b1;
            err_code_d = ERR_RANGE;
          end else begin
            mem_we_d = 1'b1;
            wa_d     = ld_addr;
            wdata_d  = ld_data;
            if (beat_hlt) hlt_seen_d = 1'b1;
            if (ld_last) begin
              if (hlt_seen_q || beat_hlt) begin
                fin_d = 1'b1;
              end else begin
                state_d    = LD_ERR;
                err_d      = 1'b1;
                err_code_d = ERR_NOHLT;
              end
            end
          end
        end
      end
      LD_RUN: begin
        wd_d = wd_q + 32'd1;
        // wd_q == 0 marks the first RUN cycle, where HALTED is still stale.
        if ((wd_q != '0) && cpu_halted) begin
          wd_d = '0;
          if (count_q == '0) begin
            state_d = LD_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = LD_DUMP;
            dump_go = 1'b1;
          end
        end else if (wd_q == 32'(TIMEOUT_CYCLES - 1)) begin
          wd_d       = '0;
          state_d    = LD_ERR;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end
      end
      LD_DUMP: begin
        if (seq_last) begin
          state_d = LD_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = LD_IDLE;
    endcase
    cpu_run_d = (state_d == LD_RUN);
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q    <= LD_IDLE;
      hlt_seen_q <= 1'b0;
      fin_q      <= 1'b0;
      wd_q       <= '0;
      base_q     <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      cpu_run_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      wa_q       <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      hlt_seen_q <= hlt_seen_d;
      fin_q      <= fin_d;
      wd_q       <= wd_d;
      base_q     <= base_d;
      count_q    <= count_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      cpu_run_q  <= cpu_run_d;
      mem_we_q   <= mem_we_d;
      wa_q       <= wa_d;
      wdata_q    <= wdata_d;
    end
  end

  mips32_dump_seq #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_dump_seq (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .go         (dump_go),
    .base       (base_q),
    .count      (count_q),
    .mem_rdata  (mem_rdata),
    .mem_re     (seq_re),
    .rd_addr    (seq_addr),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_last  (seq_last)
  );

  // Write and read addresses are both zero when unused and never overlap.
  assign mem_addr  = wa_q | seq_addr;
  assign mem_we    = mem_we_q;
  assign mem_re    = seq_re;
  assign mem_wdata = wdata_q;
  assign cpu_run   = cpu_run_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_mips32_boot_loader.sv
// tb/tb_mips32_boot_loader.sv - directed bench for mips32_boot_loader
module tb_mips32_boot_loader;

  localparam int AW = 11;
  localparam int DW = 32;

  logic          clk1 = 1'b0;
  logic          rst_n, start, ld_valid, ld_last, cpu_halted;
  logic [AW-1:0] dump_base, dump_count, ld_addr;
  logic [DW-1:0] ld_data;
  logic [DW-1:0] mem_rdata = '0;
  logic          ld_ready, mem_we, mem_re, cpu_run, dump_valid, done, err;
  logic [AW-1:0] mem_addr, dump_addr;
  logic [DW-1:0] mem_wdata, dump_data;
  logic [1:0]    err_code;

  mips32_boot_loader #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(1024), .TIMEOUT_CYCLES(1000), .HLT_OPCODE(6'h3f)
  ) dut (
    .clk1(clk1), .rst_n(rst_n), .start(start), .dump_base(dump_base), .dump_count(dump_count),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_run(cpu_run), .cpu_halted(cpu_halted),
    .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data),
    .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk1 = ~clk1;

  // Mem model, core result poke and activity logs
  logic [DW-1:0] mem [0:2047];
  logic [AW-1:0] dv_addr [0:63];
  logic [DW-1:0] dv_data [0:63];
  logic [AW-1:0] last_wa = '0;
  logic          poke_en = 1'b0;
  int wr_cnt = 0, wr_oob = 0, re_cnt = 0, run_cnt = 0, dv_cnt = 0;

  always @(posedge clk1) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
      last_wa <= mem_addr;
      if (mem_addr >= 11'd1024) wr_oob <= wr_oob + 1;
    end else if (poke_en) begin
      mem[121] <= 32'd130;
    end
    mem_rdata <= mem_re ? mem[mem_addr] : 32'hdead_beef;
    if (mem_re) re_cnt <= re_cnt + 1;
    if (cpu_run) run_cnt <= run_cnt + 1;
    if (dump_valid) begin
      dv_addr[dv_cnt & 63] <= dump_addr;
      dv_data[dv_cnt & 63] <= dump_data;
      dv_cnt <= dv_cnt + 1;
    end
  end

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] img [0:7];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {ld_ready, mem_we, mem_re, cpu_run, dump_valid, done, err, err_code}, 64'd0);
    chk({tag, "_addr"}, {mem_addr, dump_addr}, 64'd0);
    chk({tag, "_data"}, {mem_wdata, dump_data}, 64'd0);
  endtask

  task automatic start_session(input logic [AW-1:0] b, input logic [AW-1:0] c);
    dump_base = b; dump_count = c; start = 1'b1;
    @(negedge clk1);
    start = 1'b0; dump_base = '0; dump_count = '0;
  endtask

  task automatic send_beat(input logic [AW-1:0] a, input logic [31:0] d, input logic l);
    int t = 0;
    ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = l;
    while (!ld_ready && t < 20) begin @(negedge clk1); t++; end
    chk("ld_ready_wait", ld_ready, 1);
    @(negedge clk1);
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic load_image(input logic with_hlt);
    for (int i = 0; i < 8; i++)
      send_beat(AW'(i), (i == 7 && !with_hlt) ? 32'h0c631800 : img[i], 1'b0);
    send_beat(11'd120, 32'd85, 1'b1);
  endtask

  // Returns at the negedge right after the edge that samples the halt.
  task automatic run_to_halt(input int cycles);
    int t = 0;
    while (!cpu_run && t < 50) begin @(negedge clk1); t++; end
    chk("run_start", cpu_run, 1);
    cpu_halted = 1'b1;               // stale HALTED during first RUN cycle
    @(negedge clk1);
    cpu_halted = 1'b0;
    chk("stale_halt_ignored", cpu_run, 1);
    poke_en = 1'b1;
    @(negedge clk1);
    poke_en = 1'b0;
    repeat (cycles) @(negedge clk1);
    cpu_halted = 1'b1;
    @(negedge clk1);
    cpu_halted = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 50) begin @(negedge clk1); t++; end
    chk("done_reached", done, 1);
  endtask

  task automatic session1();
    int w0, r0, d0;
    w0 = wr_cnt;
    start_session(11'd120, 11'd2);
    load_image(1'b1);
    chk("final_write_before_run", {mem_we, cpu_run, mem_addr}, {1'b1, 1'b0, 11'd120});
    @(negedge clk1);
    chk("run_after_write", {mem_we, cpu_run}, 2'b01);
    chk("s1_writes", wr_cnt - w0, 9);
    r0 = re_cnt; d0 = dv_cnt;
    run_to_halt(4);
    chk("s1_first_read", {cpu_run, mem_re, mem_addr}, {1'b0, 1'b1, 11'd120});
    wait_done();
    chk("s1_dump_cnt", dv_cnt - d0, 2);
    chk("s1_dump0", {dv_addr[d0 & 63], dv_data[d0 & 63]}, {11'd120, 32'd85});
    chk("s1_dump1", {dv_addr[(d0 + 1) & 63], dv_data[(d0 + 1) & 63]}, {11'd121, 32'd130});
    chk("s1_reads", re_cnt - r0, 2);
    chk("s1_status", {done, err, err_code}, 4'b1000);
  endtask

  initial begin
    int w0, r0, d0, o0, t;
    img[0] = 32'h28010078; img[1] = 32'h0c631800; img[2] = 32'h20220000; img[3] = 32'h0c631800;
    img[4] = 32'h2842002d; img[5] = 32'h0c631800; img[6] = 32'h24220001; img[7] = 32'hfc000000;
    rst_n = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; cpu_halted = 1'b0;
    dump_base = '0; dump_count = '0; ld_addr = '0; ld_data = '0;
    repeat (2) @(negedge clk1);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk1);
    chk("idle_no_ready", ld_ready, 0);

    // 1: normal load/run/dump
    session1();

    // 2: image without HLT
    r0 = run_cnt;
    start_session(11'd120, 11'd2);
    chk("s2_done_cleared", {done, ld_ready}, 2'b01);
    load_image(1'b0);
    repeat (3) @(negedge clk1);
    chk("s2_err", {err, err_code}, {1'b1, 2'd1});
    chk("s2_no_run", run_cnt - r0, 0);

    // 3: out-of-range beat
    start_session(11'd0, 11'd0);
    chk("s3_err_cleared", {err, err_code}, 3'b000);
    w0 = wr_cnt; o0 = wr_oob;
    send_beat(11'd1023, 32'h11112222, 1'b0);
    send_beat(11'd1024, 32'hdead0000, 1'b0);
    @(negedge clk1);
    chk("s3_err", {err, err_code, ld_ready}, {1'b1, 2'd2, 1'b0});
    chk("s3_one_write", wr_cnt - w0, 1);
    chk("s3_write_addr", last_wa, 11'd1023);
    chk("s3_write_data", mem[1023], 32'h11112222);
    chk("s3_no_oob_write", wr_oob - o0, 0);

    // 4: watchdog
    start_session(11'd0, 11'd1);
    load_image(1'b1);
    r0 = run_cnt;
    t = 0;
    while (!err && t < 1200) begin @(negedge clk1); t++; end
    chk("s4_err", {err, err_code, cpu_run}, {1'b1, 2'd3, 1'b0});
    chk("s4_run_cycles", run_cnt - r0, 1000);

    // 5: reset during LOAD, then during DUMP, then a clean session
    start_session(11'd120, 11'd2);
    send_beat(11'd0, img[0], 1'b0);
    send_beat(11'd1, img[1], 1'b0);
    ld_valid = 1'b1; ld_addr = 11'd2; ld_data = img[2]; rst_n = 1'b0;
    @(negedge clk1);
    chk_zero("rst_load");
    ld_valid = 1'b0; rst_n = 1'b1;
    start_session(11'd120, 11'd2);
    load_image(1'b1);
    run_to_halt(2);
    chk("s5_in_dump", mem_re, 1);
    rst_n = 1'b0;
    @(negedge clk1);
    chk_zero("rst_dump");
    rst_n = 1'b1;
    @(negedge clk1);
    session1();

    // 6: address wrap, then empty window
    start_session(11'd1023, 11'd2);
    load_image(1'b1);
    d0 = dv_cnt;
    run_to_halt(3);
    wait_done();
    chk("s6_dump_cnt", dv_cnt - d0, 2);
    chk("s6_dump0", {dv_addr[d0 & 63], dv_data[d0 & 63]}, {11'd1023, 32'h11112222});
    chk("s6_dump1", {dv_addr[(d0 + 1) & 63], dv_data[(d0 + 1) & 63]}, {11'd0, 32'h28010078});
    start_session(11'd1023, 11'd0);
    load_image(1'b1);
    r0 = re_cnt; d0 = dv_cnt;
    run_to_halt(3);
    chk("s6_zero_done", {done, cpu_run, mem_re}, 3'b100);
    repeat (3) @(negedge clk1);
    chk("s6_zero_no_reads", re_cnt - r0, 0);
    chk("s6_zero_no_dump", dv_cnt - d0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
